// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// the NOP word that fills memory after reset, and the memory depth.
package prog_loader_pkg;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam logic [7:0] NOP = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_RUN   = 2'd3
    } state_e;
endpackage

// File: rtl/prog_loader_if.sv
// Loader bus: byte-stream handshake from the host plus the CPU fetch/control side.
// The fetch data output is named dout because "do" is a reserved word.
interface prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              load_req;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] dout;
    logic              cpu_hold;
    logic              load_done;
    logic              err;

    modport master (
        output load_req, rx_valid, rx_data, ad,
        input  rx_ready, dout, cpu_hold, load_done, err
    );
    modport slave (
        input  load_req, rx_valid, rx_data, ad,
        output rx_ready, dout, cpu_hold, load_done, err
    );
endinterface

// File: rtl/prog_loader_imem_16x8.sv
// Instruction register file: async reset to all-zero (NOP), one synchronous
// write port, one combinational read port.
module imem_16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [(1<<ADDR_W)-1:0][DATA_W-1:0] mem_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)  mem_q <= '0;
        else if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/prog_loader.sv
// Program loader: streams 16 bytes into instruction memory, holds the CPU
// meanwhile, then serves fetches. Define PROG_LOADER_CKSUM_EN for a trailing checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = prog_loader_pkg::ADDR_W,
    parameter int DATA_W = prog_loader_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          n_reset,
    prog_loader_if.slave  bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              xfer, we;
    logic [DATA_W-1:0] rdata;
`ifdef PROG_LOADER_CKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
`endif

    // State register plus the datapath registers that move with it
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
`ifdef PROG_LOADER_CKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next state: load_req takes priority everywhere and restarts from word 0
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
`ifdef PROG_LOADER_CKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        if (bus.load_req) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
`ifdef PROG_LOADER_CKSUM_EN
            sum_d   = '0;
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_LOAD: if (xfer) begin
                    ptr_d = ptr_q + 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
                    sum_d = sum_q + bus.rx_data;
                    if (ptr_q == {ADDR_W{1'b1}}) state_d = ST_CHECK;
`else
                    if (ptr_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
`endif
                end
`ifdef PROG_LOADER_CKSUM_EN
                ST_CHECK: if (xfer) begin
                    if (bus.rx_data == sum_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
        done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    // Outputs depend on state only; rx_valid never reaches rx_ready
    always_comb begin
        bus.rx_ready  = (state_q == ST_LOAD) || (state_q == ST_CHECK);
        bus.cpu_hold  = (state_q != ST_RUN);
        bus.load_done = done_q;
        bus.dout      = (state_q == ST_RUN) ? rdata : DATA_W'(NOP);
`ifdef PROG_LOADER_CKSUM_EN
        bus.err       = err_q;
`else
        bus.err       = 1'b0;
`endif
    end

    assign xfer = bus.rx_ready & bus.rx_valid;
    assign we   = xfer & (state_q == ST_LOAD) & ~bus.load_req;

    imem_16x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_imem (
        .clk     (clk),
        .n_reset (n_reset),
        .we_i    (we),
        .waddr_i (ptr_q),
        .wdata_i (bus.rx_data),
        .raddr_i (bus.ad),
        .rdata_o (rdata)
    );
endmodule
